// File: rtl/game_pkg.sv
// Shared types and widths for the game controller slice.
package game_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam int NUM_TUBES = 3;
    localparam int COORD_W   = 11;
    localparam int SCORE_W   = 10;
endpackage

// File: rtl/tube_hit_check.sv
// Combinational bird-vs-tube overlap test plus "tube already behind the bird" flag.
module tube_hit_check
    import game_pkg::*;
#(
    parameter int TUBE_WIDTH = 60,
    parameter int GAP_HEIGHT = 600,
    parameter int BIRD_X     = 200,
    parameter int BIRD_SIZE  = 32
) (
    input  logic [COORD_W-1:0] i_tube_x,
    input  logic [COORD_W-1:0] i_gap_y,
    input  logic [COORD_W-1:0] i_bird_y,
    output logic               o_hit,
    output logic               o_past
);
    localparam int CW = COORD_W + 1;
    localparam logic [CW-1:0] X_LO = CW'(BIRD_X);
    localparam logic [CW-1:0] X_HI = CW'(BIRD_X + BIRD_SIZE + TUBE_WIDTH);
    localparam logic [CW-1:0] BSZ  = CW'(BIRD_SIZE);
    localparam logic [CW-1:0] GAPH = CW'(GAP_HEIGHT);

    // One extra bit so the sums below never wrap.
    logic [CW-1:0] w_tube_x;
    logic [CW-1:0] w_gap_y;
    logic [CW-1:0] w_bird_y;
    logic          w_horiz;
    logic          w_vert;

    assign w_tube_x = {1'b0, i_tube_x};
    assign w_gap_y  = {1'b0, i_gap_y};
    assign w_bird_y = {1'b0, i_bird_y};

    assign w_horiz = (X_LO < w_tube_x) && (w_tube_x < X_HI);
    assign w_vert  = (w_bird_y < w_gap_y) || ((w_bird_y + BSZ) > (w_gap_y + GAPH));
    assign o_hit   = w_horiz && w_vert;
    assign o_past  = (w_tube_x <= X_LO);
endmodule

// File: rtl/game_ctrl.sv
// Game-state FSM: collision detection, tube scoring, best score and post-death hold.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SCREEN_HEIGHT = 768,
    parameter int TUBE_WIDTH    = 60,
    parameter int GAP_HEIGHT    = 600,
    parameter int BIRD_X        = 200,
    parameter int BIRD_SIZE     = 32,
    parameter int DEAD_HOLD     = 65_000_000,
    parameter int SCORE_MAX     = 999
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_tick,
    input  logic                                btn_flap,
    input  logic [COORD_W-1:0]                  bird_y,
    input  logic [NUM_TUBES-1:0][COORD_W-1:0]   tube_x,
    input  logic [NUM_TUBES-1:0][COORD_W-1:0]   gap_y,
    output logic                                game_rst,
    output logic [1:0]                          state,
    output logic                                collision,
    output logic [SCORE_W-1:0]                  score,
    output logic [SCORE_W-1:0]                  best_score
);
    localparam int CNT_W = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(DEAD_HOLD - 1);
    localparam logic [COORD_W:0]   FLOOR_Y   = (COORD_W+1)'(SCREEN_HEIGHT);
    localparam logic [COORD_W:0]   BSZ       = (COORD_W+1)'(BIRD_SIZE);
    localparam logic [SCORE_W:0]   SMAX_W    = (SCORE_W+1)'(SCORE_MAX);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_TUBES-1:0]   r_passed;
    logic [SCORE_W-1:0]     r_score;
    logic [SCORE_W-1:0]     r_best;
    logic                   r_collision;
    logic [CNT_W-1:0]       r_hold_cnt;

    logic [NUM_TUBES-1:0]   w_hit;
    logic [NUM_TUBES-1:0]   w_past;
    logic                   w_floor;
    logic                   w_any_hit;
    logic [1:0]             w_pass_cnt;
    logic [SCORE_W:0]       w_score_sum;
    logic [SCORE_W-1:0]     w_score_nxt;
    logic                   w_hold_done;

    for (genvar g = 0; g < NUM_TUBES; g++) begin : g_tube
        tube_hit_check #(
            .TUBE_WIDTH (TUBE_WIDTH),
            .GAP_HEIGHT (GAP_HEIGHT),
            .BIRD_X     (BIRD_X),
            .BIRD_SIZE  (BIRD_SIZE)
        ) u_hit (
            .i_tube_x (tube_x[g]),
            .i_gap_y  (gap_y[g]),
            .i_bird_y (bird_y),
            .o_hit    (w_hit[g]),
            .o_past   (w_past[g])
        );
    end

    assign w_floor   = ({1'b0, bird_y} + BSZ) >= FLOOR_Y;
    assign w_any_hit = (|w_hit) || w_floor;

    // A tube scores once when it first reaches the bird; passed re-arms once it is ahead again.
    always_comb begin
        w_pass_cnt = 2'd0;
        for (int i = 0; i < NUM_TUBES; i++) begin
            w_pass_cnt = w_pass_cnt + {1'b0, w_past[i] & ~r_passed[i]};
        end
    end

    assign w_score_sum = {1'b0, r_score} + {{(SCORE_W-1){1'b0}}, w_pass_cnt};
    assign w_score_nxt = (w_score_sum > SMAX_W) ? SMAX_W[SCORE_W-1:0] : w_score_sum[SCORE_W-1:0];
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (btn_flap) w_state_nxt = PLAY;
            PLAY:    if (frame_tick && w_any_hit) w_state_nxt = DEAD;
            DEAD:    if (w_hold_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_passed    <= '0;
            r_score     <= '0;
            r_best      <= '0;
            r_collision <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_collision <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (btn_flap) begin
                        r_score  <= '0;
                        r_passed <= '0;
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        r_score  <= w_score_nxt;
                        r_passed <= w_past;
                        if (w_any_hit) begin
                            r_collision <= 1'b1;
                            if (w_score_nxt > r_best) r_best <= w_score_nxt;
                        end
                    end
                end
                DEAD: begin
                    r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign game_rst   = (r_state == IDLE);
    assign state      = r_state;
    assign collision  = r_collision;
    assign score      = r_score;
    assign best_score = r_best;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a short post-death hold.
module tb_game_ctrl;
    import game_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               frame_tick;
    logic                               btn_flap;
    logic [COORD_W-1:0]                 bird_y;
    logic [NUM_TUBES-1:0][COORD_W-1:0]  tube_x;
    logic [NUM_TUBES-1:0][COORD_W-1:0]  gap_y;
    logic                               game_rst;
    logic [1:0]                         state;
    logic                               collision;
    logic [SCORE_W-1:0]                 score;
    logic [SCORE_W-1:0]                 best_score;

    int vectors    = 0;
    int miscompares = 0;

    game_ctrl #(.DEAD_HOLD(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .btn_flap   (btn_flap),
        .bird_y     (bird_y),
        .tube_x     (tube_x),
        .gap_y      (gap_y),
        .game_rst   (game_rst),
        .state      (state),
        .collision  (collision),
        .score      (score),
        .best_score (best_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are read one falling edge later.
    task automatic clocks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic flap();
        btn_flap = 1'b1;
        @(negedge clk);
        btn_flap = 1'b0;
    endtask

    task automatic set_tubes(input int x0, input int x1, input int x2);
        tube_x[0] = COORD_W'(x0);
        tube_x[1] = COORD_W'(x1);
        tube_x[2] = COORD_W'(x2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        frame_tick = 1'b0;
        btn_flap   = 1'b0;
        bird_y     = 11'd300;
        set_tubes(1000, 1000, 1000);
        gap_y[0] = 11'd84; gap_y[1] = 11'd84; gap_y[2] = 11'd84;
        clocks(3);
        rst = 1'b0;
        clocks(1);
        check("rst_state", state, 0);
        check("rst_game_rst", game_rst, 1);
        check("rst_score", score, 0);
        check("rst_best", best_score, 0);
        check("rst_collision", collision, 0);

        // frame_tick in IDLE must not score or change state
        set_tubes(200, 1000, 1000);
        tick();
        check("idle_tick_state", state, 0);
        check("idle_tick_score", score, 0);
        set_tubes(1000, 1000, 1000);

        flap();
        check("flap_state", state, 1);
        check("flap_game_rst", game_rst, 0);

        set_tubes(250, 1000, 1000);
        tick();
        check("safe_collision", collision, 0);
        check("safe_state", state, 1);

        bird_y = 11'd84;   // top edge touching gap top
        tick();
        check("touch_top_state", state, 1);
        bird_y = 11'd652;  // bottom edge touching gap bottom (684)
        tick();
        check("touch_bot_state", state, 1);
        bird_y = 11'd60;
        set_tubes(292, 1000, 1000);  // right edge beyond overlap window
        tick();
        check("x_edge_state", state, 1);

        set_tubes(250, 1000, 1000);
        tick();
        check("hit_collision", collision, 1);
        check("hit_state", state, 2);
        check("hit_game_rst", game_rst, 0);
        check("hit_best", best_score, 0);
        btn_flap = 1'b1;
        clocks(1);
        btn_flap = 1'b0;
        check("collision_pulse_end", collision, 0);
        check("dead_ignores_flap", state, 2);
        clocks(14);
        check("hold_still_dead", state, 2);
        clocks(1);
        check("hold_done_state", state, 0);
        check("hold_done_game_rst", game_rst, 1);

        bird_y = 11'd300;
        set_tubes(1000, 1000, 1000);
        flap();
        check("replay_state", state, 1);
        check("replay_score", score, 0);

        set_tubes(202, 1000, 1000); tick();
        check("step202_score", score, 0);
        set_tubes(201, 1000, 1000); tick();
        check("step201_score", score, 0);
        set_tubes(200, 1000, 1000); tick();
        check("step200_score", score, 1);
        for (int i = 0; i < 5; i++) tick();
        check("hold200_score", score, 1);
        set_tubes(1084, 1000, 1000); tick();
        check("wrap_score", score, 1);
        set_tubes(200, 1000, 1000); tick();
        check("rearm_score", score, 2);
        set_tubes(1000, 1000, 1000); tick();
        set_tubes(200, 200, 1000); tick();
        check("double_pass_score", score, 4);
        set_tubes(1000, 1000, 1000); tick();

        // 4 + 3*331 = 997
        for (int i = 0; i < 331; i++) begin
            set_tubes(200, 200, 200); tick();
            set_tubes(1000, 1000, 1000); tick();
        end
        check("bulk_score", score, 997);
        check("bulk_state", state, 1);
        set_tubes(200, 1000, 1000); tick();
        check("score_998", score, 998);
        set_tubes(1000, 1000, 1000); tick();
        set_tubes(200, 200, 1000); tick();
        check("saturate_999", score, 999);
        set_tubes(1000, 1000, 1000); tick();
        set_tubes(1000, 1000, 200); tick();
        check("stay_999", score, 999);

        bird_y = 11'd736;
        tick();
        check("floor_collision", collision, 1);
        check("floor_state", state, 2);
        check("floor_best", best_score, 999);
        check("floor_score", score, 999);
        clocks(5);
        check("mid_hold_state", state, 2);
        rst = 1'b1;
        clocks(1);
        rst = 1'b0;
        check("rst_dead_state", state, 0);
        check("rst_dead_best", best_score, 0);
        check("rst_dead_score", score, 0);
        check("rst_dead_game_rst", game_rst, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
